// File: rtl/keypad_scan_fifo.sv
// rtl/keypad_scan_fifo.sv - column-scanned keypad with per-key debounce and a press/release event FIFO
// One column is driven per slot; its rows are sampled once and then evaluated one key per cycle.
module keypad_scan_fifo #(
  parameter int NCOL       = 4,
  parameter int NROW       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CNT    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       iclk,
  input  logic                       inrest,
  input  logic [NROW-1:0]            iROW,
  output logic [NCOL-1:0]            oCOL,
  output logic [NROW*NCOL-1:0]       oKEYST,
  output logic [$clog2(NROW*NCOL):0] oEVT_DATA,
  output logic                       oEVT_VALID,
  input  logic                       iEVT_POP,
  output logic                       oOVF,
  input  logic                       iOVF_CLR,
  input  logic                       iIRQ_EN,
  output logic                       oIRQ
);
  localparam int NKEY = NROW * NCOL;
  localparam int KW   = $clog2(NKEY);
  localparam int SW   = $clog2(SCAN_DIV);
  localparam int CW   = $clog2(NCOL);
  localparam int RW   = $clog2(NROW);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [SW-1:0] SETTLE_END = SW'(SCAN_DIV - NROW - 3);

  typedef enum logic [1:0] {SETTLE, SAMPLE, EMIT, NEXT} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [CW-1:0]   c_q, c_d;
  logic [RW-1:0]   r_q, r_d;
  logic [NCOL-1:0] col_q, col_d;
  logic [NROW-1:0] sync1_q, sync2_q, row_q, row_d;
  logic [NKEY-1:0] keyst_q, keyst_d;
  logic [3:0]      dcnt_q [NKEY];
  logic [3:0]      dcnt_d [NKEY];

  logic [KW-1:0]   code;
  logic            raw;
  logic            push;
  logic [KW:0]     push_data;

  logic [KW:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wp_q, rp_q;
  logic [AW:0]     fcnt_q;
  logic            full, empty, do_pop, do_push, drop;
  logic            ovf_q, irq_q;

  assign code = KW'(int'(r_q) * NCOL + int'(c_q));
  assign raw  = ~row_q[r_q];

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q + SW'(1);
    c_d     = c_q;
    r_d     = r_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      SETTLE: if (slot_q == SETTLE_END) state_d = SAMPLE;
      SAMPLE: begin
        row_d   = sync2_q;
        r_d     = '0;
        state_d = EMIT;
      end
      EMIT: begin
        r_d = r_q + RW'(1);
        if (r_q == RW'(NROW - 1)) state_d = NEXT;
      end
      NEXT: begin
        slot_d  = '0;
        c_d     = (c_q == CW'(NCOL - 1)) ? '0 : c_q + CW'(1);
        col_d   = ~(NCOL'(1) << c_d);
        state_d = SETTLE;
      end
      default: state_d = SETTLE;
    endcase
  end

  // A commit flips the stored state, so the event bit is simply the new raw level.
  always_comb begin
    keyst_d   = keyst_q;
    dcnt_d    = dcnt_q;
    push      = 1'b0;
    push_data = '0;
    if (state_q == EMIT) begin
      if (raw == keyst_q[code]) begin
        dcnt_d[code] = '0;
      end else if (dcnt_q[code] == 4'(DEB_CNT - 1)) begin
        keyst_d[code] = raw;
        dcnt_d[code]  = '0;
        push          = 1'b1;
        push_data     = {raw, code};
      end else begin
        dcnt_d[code] = dcnt_q[code] + 4'd1;
      end
    end
  end

  assign full    = (fcnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (fcnt_q == '0);
  assign do_pop  = iEVT_POP & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_ff @(posedge iclk or negedge inrest) begin
    if (!inrest) begin
      state_q <= SETTLE;
      slot_q  <= '0;
      c_q     <= '0;
      r_q     <= '0;
      col_q   <= {{(NCOL-1){1'b1}}, 1'b0};
      sync1_q <= '1;
      sync2_q <= '1;
      row_q   <= '1;
      keyst_q <= '0;
      for (int i = 0; i < NKEY; i++) dcnt_q[i] <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      fcnt_q  <= '0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      c_q     <= c_d;
      r_q     <= r_d;
      col_q   <= col_d;
      sync1_q <= iROW;
      sync2_q <= sync1_q;
      row_q   <= row_d;
      keyst_q <= keyst_d;
      dcnt_q  <= dcnt_d;
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      fcnt_q  <= fcnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (drop)          ovf_q <= 1'b1;
      else if (iOVF_CLR) ovf_q <= 1'b0;
      irq_q   <= iIRQ_EN & (~empty | ovf_q);
    end
  end

  always_ff @(posedge iclk) begin
    if (do_push) mem_q[wp_q] <= push_data;
  end

  assign oCOL       = col_q;
  assign oKEYST     = keyst_q;
  assign oEVT_DATA  = mem_q[rp_q];
  assign oEVT_VALID = ~empty;
  assign oOVF       = ovf_q;
  assign oIRQ       = irq_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb/tb_keypad_scan_fifo.sv - self-checking bench for keypad_scan_fifo
module tb_keypad_scan_fifo;
  localparam int NC = 4, NR = 4, SD = 16, DB = 4, DEP = 8;
  localparam int SCAN = NC * SD;

  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic        inrest, pop, clr, irq_en;
  logic [15:0] keys;
  logic [3:0]  row, col;
  logic [15:0] keyst;
  logic [4:0]  data;
  logic        valid, ovf, irq;

  logic        rst2;
  logic [2:0]  row2;
  logic [1:0]  col2;
  logic [5:0]  keyst2;
  logic [3:0]  data2;
  logic        valid2, ovf2, irq2;
  logic        pop2, clr2, irqen2;

  // Physical keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    for (int r = 0; r < NR; r++) row[r] = ~|(keys[r*NC +: NC] & ~col);
  end
  assign row2 = {col2[1], 2'b11};

  keypad_scan_fifo #(.NCOL(NC), .NROW(NR), .SCAN_DIV(SD), .DEB_CNT(DB), .FIFO_DEPTH(DEP)) dut (
    .iclk(iclk), .inrest(inrest), .iROW(row), .oCOL(col), .oKEYST(keyst),
    .oEVT_DATA(data), .oEVT_VALID(valid), .iEVT_POP(pop), .oOVF(ovf),
    .iOVF_CLR(clr), .iIRQ_EN(irq_en), .oIRQ(irq)
  );

  keypad_scan_fifo #(.NCOL(2), .NROW(3), .SCAN_DIV(8), .DEB_CNT(1), .FIFO_DEPTH(8)) dut2 (
    .iclk(iclk), .inrest(rst2), .iROW(row2), .oCOL(col2), .oKEYST(keyst2),
    .oEVT_DATA(data2), .oEVT_VALID(valid2), .iEVT_POP(pop2), .oOVF(ovf2),
    .iOVF_CLR(clr2), .iIRQ_EN(irqen2), .oIRQ(irq2)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scan-level model: cycle k of a scan tells which column/row is sampled or judged.
  logic [4:0]  mq[$];
  logic [15:0] m_keyst;
  int          m_cnt [16];
  logic [3:0]  m_samp;
  bit          m_ovf, m_irq, m_irq_n, mev, mpop, mdrop;
  logic [4:0]  mevd;
  int          mk, ms, mc, mr, mcode;

  always @(posedge iclk or negedge inrest) begin
    if (!inrest) begin
      mq.delete();
      m_keyst = '0;
      m_samp  = '0;
      m_ovf   = 0;
      m_irq   = 0;
      mk      = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      ms  = mk % SD;
      mc  = (mk / SD) % NC;
      mev = 0;
      m_irq_n = irq_en && (mq.size() != 0 || m_ovf);
      if (ms == SD - NR - 2)
        for (int r = 0; r < NR; r++) m_samp[r] = keys[r*NC + mc];
      if (ms >= SD - NR - 1 && ms <= SD - 2) begin
        mr    = ms - (SD - NR - 1);
        mcode = mr * NC + mc;
        if (m_samp[mr] == m_keyst[mcode]) begin
          m_cnt[mcode] = 0;
        end else begin
          m_cnt[mcode]++;
          if (m_cnt[mcode] == DB) begin
            m_keyst[mcode] = ~m_keyst[mcode];
            m_cnt[mcode]   = 0;
            mev  = 1;
            mevd = {m_keyst[mcode], 4'(mcode)};
          end
        end
      end
      mpop  = pop && mq.size() != 0;
      mdrop = 0;
      if (mpop) void'(mq.pop_front());
      if (mev) begin
        if (mq.size() == DEP) mdrop = 1;
        else mq.push_back(mevd);
      end
      if (mdrop)    m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_irq = m_irq_n;
      mk++;
    end
  end

  always @(negedge iclk) begin
    if (inrest === 1'b1) begin
      check("col", 32'(col), 32'(4'(~(4'd1 << ((mk / SD) % NC)))));
      check("keyst", 32'(keyst), 32'(m_keyst));
      check("valid", 32'(valid), 32'(mq.size() != 0));
      if (mq.size() != 0) check("data", 32'(data), 32'(mq[0]));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("irq", 32'(irq), 32'(m_irq));
    end
  end

  int now_k;
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge iclk);
      #2;
    end
    now_k += n;
  endtask
  task automatic align();
    cyc((SCAN - now_k % SCAN) % SCAN);
  endtask

  logic [4:0] exp_seq [8] = '{5'h15, 5'h1A, 5'h1F, 5'h00, 5'h05, 5'h0A, 5'h0F, 5'h00};

  initial begin
    inrest = 0; pop = 0; clr = 0; irq_en = 1; keys = '0; now_k = 0;
    rst2 = 0; pop2 = 0; clr2 = 0; irqen2 = 0;
    repeat (3) @(posedge iclk);
    #2;
    check("rst_col", 32'(col), 32'h0E);
    check("rst_keyst", 32'(keyst), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    inrest = 1; now_k = 0;

    pop = 1; cyc(1); pop = 0;
    check("pop_empty_valid", 32'(valid), 32'h0);

    align();
    keys[6] = 1'b1; cyc(5 * SCAN);
    check("press6_keyst", 32'(keyst), 32'h0040);
    check("press6_valid", 32'(valid), 32'h1);
    check("press6_data", 32'(data), 32'h16);
    check("press6_irq", 32'(irq), 32'h1);
    pop = 1; cyc(1); pop = 0;
    check("press6_single", 32'(valid), 32'h0);
    align();
    keys[6] = 1'b0; cyc(5 * SCAN);
    check("rel6_keyst", 32'(keyst), 32'h0);
    check("rel6_data", 32'(data), 32'h06);
    pop = 1; cyc(1); pop = 0;

    align();
    for (int i = 0; i < 8; i++) begin
      keys[3] = (i % 2 == 0);
      cyc(SCAN);
    end
    keys[3] = 1'b0; cyc(5 * SCAN);
    check("bounce_keyst", 32'(keyst), 32'h0);
    check("bounce_valid", 32'(valid), 32'h0);

    keys = 16'h8421; cyc(5 * SCAN);
    keys = 16'h0000; cyc(5 * SCAN);
    check("fill_head", 32'(data), 32'h10);
    check("fill_ovf", 32'(ovf), 32'h0);
    keys[0] = 1'b1; cyc(5 * SCAN);
    check("drop_ovf", 32'(ovf), 32'h1);
    check("drop_keyst", 32'(keyst), 32'h0001);
    check("drop_head", 32'(data), 32'h10);
    clr = 1; cyc(1); clr = 0;
    check("ovf_clr", 32'(ovf), 32'h0);

    align();
    keys[0] = 1'b0;
    cyc(3 * SCAN + SD - NR - 1);
    check("coinc_head", 32'(data), 32'h10);
    pop = 1; cyc(1);
    for (int i = 0; i < 8; i++) begin
      check("coinc_seq", 32'(data), 32'(exp_seq[i]));
      cyc(1);
    end
    pop = 0;
    check("coinc_drained", 32'(valid), 32'h0);
    check("coinc_ovf", 32'(ovf), 32'h0);

    align();
    keys = 16'h000E; cyc(5 * SCAN);
    check("rst3_valid", 32'(valid), 32'h1);
    cyc(12);
    inrest = 0;
    #1;
    check("arst_valid", 32'(valid), 32'h0);
    check("arst_keyst", 32'(keyst), 32'h0);
    check("arst_col", 32'(col), 32'h0E);
    check("arst_irq", 32'(irq), 32'h0);
    keys = '0;
    cyc(3);
    inrest = 1; now_k = 0;
    cyc(2 * SCAN);
    check("post_rst_valid", 32'(valid), 32'h0);

    rst2 = 1;
    for (int k = 0; k < 24; k++) begin
      check("small_col", 32'(col2), ((k / 8) % 2 == 0) ? 32'h2 : 32'h1);
      if (k == 14) check("small_early", 32'(valid2), 32'h0);
      if (k == 15) begin
        check("small_valid", 32'(valid2), 32'h1);
        check("small_data", 32'(data2), 32'hD);
        check("small_keyst", 32'(keyst2), 32'h20);
      end
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
